// File: rtl/adh_pkg.sv
// adh_pkg: shared constants for the ABH address-high sequencer.
// Holds mode codes, op field codes, the state enum and an op builder.
package adh_pkg;

  localparam logic [2:0] MODE_ZP     = 3'd0;
  localparam logic [2:0] MODE_STACK  = 3'd1;
  localparam logic [2:0] MODE_ABS    = 3'd2;
  localparam logic [2:0] MODE_ABSX   = 3'd3;
  localparam logic [2:0] MODE_ABSXW  = 3'd4;
  localparam logic [2:0] MODE_BRANCH = 3'd5;
  localparam logic [2:0] MODE_PCRET  = 3'd6;
  localparam logic [2:0] MODE_RSVD   = 3'd7;

  localparam logic [1:0] BASE_ZERO = 2'b00;
  localparam logic [1:0] BASE_ABH  = 2'b01;
  localparam logic [1:0] BASE_PCH  = 2'b10;
  localparam logic [1:0] BASE_DB   = 2'b11;

  localparam logic [1:0] ADD_0      = 2'b00;
  localparam logic [1:0] ADD_1      = 2'b01;
  localparam logic [1:0] ADD_CI     = 2'b10;
  localparam logic [1:0] ADD_DEC_CI = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    S_A   = 2'd1,
    S_FIX = 2'd2,
    S_PC  = 2'd3
  } state_e;

  function automatic logic [3:0] mk_op(
    input logic [1:0] base,
    input logic [1:0] add
  );
    return {base, add};
  endfunction

endpackage

// File: rtl/adh_seq.sv
// adh_seq: ABH op sequencer with page-fixup and PCH-load cycles.
// In: clk, RST, req, mode[2:0], neg, CI, rdy. Out: ack, op[3:0],
// ld_pc, inc_pc, busy, done.
module adh_seq
  import adh_pkg::*;
(
  input  logic       clk,
  input  logic       RST,
  input  logic       req,
  input  logic [2:0] mode,
  input  logic       neg,
  input  logic       CI,
  input  logic       rdy,
  output logic       ack,
  output logic [3:0] op,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       busy,
  output logic       done
);

  state_e     state_q, state_d;
  logic [2:0] mode_q;
  logic       neg_q;
  logic       carry_q, carry_d;
  logic       go;

  // Outputs only act on ready cycles and never while reset is held.
  assign go     = rdy & ~RST;
  assign busy   = (state_q != IDLE) & ~RST;
  assign inc_pc = 1'b0;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      mode_q  <= MODE_ZP;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      if (ack) begin
        mode_q <= mode;
        neg_q  <= neg;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    if (rdy) begin
      unique case (state_q)
        IDLE: begin
          if (req) state_d = S_A;
        end
        S_A: begin
          case (mode_q)
            MODE_ABSX: begin
              carry_d = CI;
              state_d = CI ? S_FIX : IDLE;
            end
            MODE_ABSXW: begin
              carry_d = CI;
              state_d = S_FIX;
            end
            MODE_BRANCH: state_d = S_PC;
            default:     state_d = IDLE;
          endcase
        end
        S_FIX: begin
          carry_d = 1'b0;
          state_d = IDLE;
        end
        S_PC: state_d = IDLE;
      endcase
    end
    // A request accepted on a final cycle chains straight into S_A.
    if (ack) state_d = S_A;
  end

  always_comb begin
    op    = mk_op(BASE_ABH, ADD_0);
    ack   = 1'b0;
    done  = 1'b0;
    ld_pc = 1'b0;
    if (go) begin
      unique case (state_q)
        IDLE: ;
        S_A: begin
          case (mode_q)
            MODE_ZP: begin
              op   = mk_op(BASE_ZERO, ADD_0);
              done = 1'b1;
            end
            MODE_STACK: begin
              op   = mk_op(BASE_ZERO, ADD_1);
              done = 1'b1;
            end
            MODE_ABS: begin
              op   = mk_op(BASE_DB, ADD_0);
              done = 1'b1;
            end
            MODE_ABSX: begin
              op   = mk_op(BASE_DB, ADD_0);
              done = ~CI;
            end
            MODE_ABSXW: begin
              op = mk_op(BASE_DB, ADD_0);
            end
            MODE_BRANCH: begin
              op = neg_q ? mk_op(BASE_ABH, ADD_DEC_CI)
                         : mk_op(BASE_ABH, ADD_CI);
            end
            default: begin
              op   = mk_op(BASE_PCH, ADD_CI);
              done = 1'b1;
            end
          endcase
        end
        S_FIX: begin
          op   = carry_q ? mk_op(BASE_ABH, ADD_1)
                         : mk_op(BASE_ABH, ADD_0);
          done = 1'b1;
        end
        S_PC: begin
          ld_pc = 1'b1;
          done  = 1'b1;
        end
      endcase
      ack = req & ((state_q == IDLE) | done);
    end
  end

endmodule

// File: tb/tb_adh_seq.sv
// tb_adh_seq: scoreboard bench for adh_seq.
// Driver issues requests; a negedge monitor checks against a queue.
module tb_adh_seq;

  logic       clk = 1'b0;
  logic       RST, req, neg, CI, rdy;
  logic [2:0] mode;
  logic       ack, ld_pc, inc_pc, busy, done;
  logic [3:0] op;

  typedef struct packed {
    logic [3:0] op;
    logic       ld;
    logic       dn;
  } cyc_t;

  cyc_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   acked = 0;
  bit   stall_en = 0;
  logic pend_ci = 1'b0;

  adh_seq dut (
    .clk(clk), .RST(RST), .req(req), .mode(mode), .neg(neg),
    .CI(CI), .rdy(rdy), .ack(ack), .op(op), .ld_pc(ld_pc),
    .inc_pc(inc_pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [8:0] act,
                     input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] o, input logic l,
                      input logic d);
    cyc_t c;
    c.op = o;
    c.ld = l;
    c.dn = d;
    q.push_back(c);
  endtask

  // Reference: cycle-by-cycle response of one request from its
  // mode, offset sign and the carry seen in its address cycle.
  task automatic push_req(input logic [2:0] m, input logic n,
                          input logic c);
    case (m)
      3'd0: push(4'b0000, 0, 1);
      3'd1: push(4'b0001, 0, 1);
      3'd2: push(4'b1100, 0, 1);
      3'd3: begin
        if (c) begin
          push(4'b1100, 0, 0);
          push(4'b0101, 0, 1);
        end else begin
          push(4'b1100, 0, 1);
        end
      end
      3'd4: begin
        push(4'b1100, 0, 0);
        push(c ? 4'b0101 : 4'b0100, 0, 1);
      end
      3'd5: begin
        push(n ? 4'b0111 : 4'b0110, 0, 0);
        push(4'b0100, 1, 1);
      end
      default: push(4'b1010, 0, 1);
    endcase
  endtask

  always @(negedge clk) begin : monitor
    cyc_t it;
    bit   last;
    bit   ea;
    if (RST) begin
      chk("reset", {op, ack, done, busy, ld_pc, inc_pc},
          {4'b0100, 5'b0});
      q.delete();
    end else begin
      chk("inc_pc", {8'b0, inc_pc}, 9'd0);
      chk("busy", {8'b0, busy}, {8'b0, q.size() != 0});
      if (!rdy) begin
        chk("stall", {5'b0, op} << 3 | {6'b0, ack, done, ld_pc},
            {2'b0, 4'b0100, 3'b000});
      end else begin
        last = 1'b1;
        if (q.size() != 0) begin
          it = q.pop_front();
          chk("op", {5'b0, op}, {5'b0, it.op});
          chk("done", {8'b0, done}, {8'b0, it.dn});
          chk("ld_pc", {8'b0, ld_pc}, {8'b0, it.ld});
          last = it.dn;
        end else begin
          chk("idle", {3'b0, op, done, ld_pc},
              {3'b0, 4'b0100, 2'b00});
        end
        ea = req && last;
        chk("ack", {8'b0, ack}, {8'b0, ea});
        if (ea) begin
          push_req(mode, neg, pend_ci);
          acked = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (stall_en) rdy = ($urandom % 4) != 0;
  endtask

  task automatic issue(input logic [2:0] m, input logic n,
                       input logic c, input int gap);
    int i;
    repeat (gap) tick();
    acked   = 1'b0;
    req     = 1'b1;
    mode    = m;
    neg     = n;
    pend_ci = c;
    i = 0;
    while (!acked && i < 60) begin
      tick();
      i++;
    end
    checks++;
    if (!acked) begin
      errors++;
      $display("FAIL ack_timeout actual=0 required=1 t=%0t", $time);
    end
    req   = 1'b0;
    CI    = c;
    acked = 1'b0;
  endtask

  initial begin
    RST  = 1'b1;
    req  = 1'b0;
    mode = 3'd0;
    neg  = 1'b0;
    CI   = 1'b0;
    rdy  = 1'b1;
    tick();
    tick();
    RST = 1'b0;

    issue(3'd3, 0, 0, 1);
    issue(3'd3, 0, 1, 2);
    issue(3'd4, 0, 0, 2);
    issue(3'd5, 1, 0, 2);
    issue(3'd5, 0, 1, 2);
    issue(3'd0, 0, 0, 2);
    issue(3'd1, 0, 0, 0);
    issue(3'd7, 0, 1, 2);
    issue(3'd6, 0, 0, 0);

    issue(3'd4, 0, 1, 2);
    tick();
    rdy = 1'b0;
    tick();
    tick();
    tick();
    rdy = 1'b1;

    issue(3'd5, 1, 0, 3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    issue(3'd2, 0, 0, 1);

    stall_en = 1'b1;
    for (int k = 0; k < 150; k++)
      issue(3'($urandom % 8), 1'($urandom % 2),
            1'($urandom % 2), int'($urandom % 3));

    stall_en = 1'b0;
    rdy = 1'b1;
    for (int k = 0; k < 10 && q.size() != 0; k++) tick();
    tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
